alu_uart_interface: RTL and testbench
=====================================

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 Parameter BITS_SIZE, default 32, operand/result width; SHALL be a multiple of BITS_DATA.
REQ-002 Parameter BITS_DATA, default 8, UART byte width.
REQ-003 Parameter BITS_OP, default 6, ALU operation code width.
REQ-004 Parameter BITS_SHAMT, default 5, shift amount width.
REQ-005 i_clk  in  1  single clock; all logic rising-edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_rx_data  in  BITS_DATA  received byte, valid when i_rx_done=1.
REQ-008 i_rx_done  in  1  one-cycle pulse, new byte available.
REQ-009 i_tx_done  in  1  one-cycle pulse, transmitter finished the current byte.
REQ-010 i_alu_result  in  BITS_SIZE  ALU combinational result.
REQ-011 i_alu_zero  in  1  ALU zero flag.
REQ-012 o_data_a / o_data_b  out  BITS_SIZE  ALU operands.
REQ-013 o_op  out  BITS_OP  ALU operation code.
REQ-014 o_alu_shamt  out  BITS_SHAMT, o_flag_shamt  out  1  shift controls.
REQ-015 o_tx_data  out  BITS_DATA, o_tx_start  out  1  byte to send, one-cycle start pulse.

Function
REQ-016 Frame in: 4 bytes A, 4 bytes B (both LSB first), 1 op byte, 1 shift byte; total 10 bytes.
REQ-017 Op byte: bits[BITS_OP-1:0] -> o_op; upper bits ignored.
REQ-018 Shift byte: bit7 -> o_flag_shamt, bits[BITS_SHAMT-1:0] -> o_alu_shamt; others ignored.
REQ-019 States: RX_A, RX_B, RX_OP, RX_SHIFT, EXEC, TX_LOAD, TX_WAIT.
REQ-020 RX_A/RX_B: each i_rx_done shifts byte into operand at position byte_cnt; after 4th byte, byte_cnt wraps to 0 and state advances.
REQ-021 RX_OP -> RX_SHIFT on i_rx_done; RX_SHIFT -> EXEC on i_rx_done.
REQ-022 EXEC lasts exactly 1 cycle; at its end latch i_alu_result and i_alu_zero into result/status registers; go to TX_LOAD.
REQ-023 Frame out: 4 result bytes LSB first, then status byte {7'b0, zero}; 5 bytes total.
REQ-024 TX_LOAD: drive o_tx_data with next byte, assert o_tx_start for exactly 1 cycle, go to TX_WAIT.
REQ-025 TX_WAIT: hold o_tx_data stable; on i_tx_done go to TX_LOAD, or to RX_A after 5th byte.
REQ-026 i_rx_done in EXEC, TX_LOAD, TX_WAIT SHALL be dropped, no state change.
REQ-027 i_tx_done outside TX_WAIT SHALL be ignored.
REQ-028 Operand, op and shift outputs SHALL hold last received values until overwritten by a new frame.
REQ-029 Latency: o_tx_start for byte 0 asserts 2 cycles after the cycle i_rx_done delivers shift byte.

Reset
REQ-030 i_reset (any state, mid-frame included) SHALL clear o_data_a, o_data_b, o_op, o_alu_shamt, o_flag_shamt, o_tx_data, o_tx_start, result, status, byte_cnt to 0 and enter RX_A on the next edge.
REQ-031 Reset SHALL dominate i_rx_done and i_tx_done in the same cycle.

Structure
REQ-032 State encoding, frame byte counts (RX 10, TX 5) and ALU opcode constants SHALL live in the shared package used by the ALU.
REQ-033 Single module, no sub-module; instantiation with alu, rx, tx done in the separate top level.

Verification
REQ-034 A=0x00000005, B=0x00000003, op 0x20, shift 0x00 -> TX bytes 08 00 00 00 00.
REQ-035 A=B=0x12345678, op 0x22 (SUB) -> TX 00 00 00 00 01.
REQ-036 B=0x00000001, op 0x00 (SLL), shift 0x84 -> o_flag_shamt=1, o_alu_shamt=4, TX 10 00 00 00 00.
REQ-037 Extra i_rx_done pulses during TX_WAIT with i_tx_done delayed 20 cycles -> no extra bytes, exactly 5 o_tx_start pulses, o_tx_data stable while waiting.
REQ-038 i_reset after 6 RX bytes, then full frame A=0xFFFFFFFF, B=1, op 0x20 -> TX 00 00 00 00 01, no residue from aborted frame.

Source files
------------

// File: rtl/alu_uart_interface_pkg.sv
// Shared types and constants for the ALU <-> UART frame bridge.
// Also holds the ALU opcode map used by the ALU and its drivers.
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
    RX_SHIFT,
    EXEC,
    TX_LOAD,
    TX_WAIT
  } state_t;

  localparam int RX_FRAME_BYTES = 10;
  localparam int TX_FRAME_BYTES = 5;

  localparam logic [5:0] OP_SLL = 6'h00;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SLT = 6'h2a;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundle of UART byte handshake and ALU operand/result signals.
// master drives the bridge inputs, slave is the bridge itself.
interface alu_uart_interface_if #(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_DATA  = 8,
  parameter int BITS_OP    = 6,
  parameter int BITS_SHAMT = 5
);
  logic [BITS_DATA-1:0]  rx_data;
  logic                  rx_done;
  logic                  tx_done;
  logic [BITS_DATA-1:0]  tx_data;
  logic                  tx_start;
  logic [BITS_SIZE-1:0]  alu_result;
  logic                  alu_zero;
  logic [BITS_SIZE-1:0]  data_a;
  logic [BITS_SIZE-1:0]  data_b;
  logic [BITS_OP-1:0]    op;
  logic [BITS_SHAMT-1:0] shamt;
  logic                  flag_shamt;

  modport master (
    output rx_data, rx_done, tx_done,
    output alu_result, alu_zero,
    input  tx_data, tx_start,
    input  data_a, data_b, op,
    input  shamt, flag_shamt
  );

  modport slave (
    input  rx_data, rx_done, tx_done,
    input  alu_result, alu_zero,
    output tx_data, tx_start,
    output data_a, data_b, op,
    output shamt, flag_shamt
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects an operand/op/shift frame from the UART, runs the ALU once,
// then streams the result bytes and a zero-status byte back out.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_DATA  = 8,
  parameter int BITS_OP    = 6,
  parameter int BITS_SHAMT = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [BITS_DATA-1:0]  i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic [BITS_SIZE-1:0]  i_alu_result,
  input  logic                  i_alu_zero,
  output logic [BITS_SIZE-1:0]  o_data_a,
  output logic [BITS_SIZE-1:0]  o_data_b,
  output logic [BITS_OP-1:0]    o_op,
  output logic [BITS_SHAMT-1:0] o_alu_shamt,
  output logic                  o_flag_shamt,
  output logic [BITS_DATA-1:0]  o_tx_data,
  output logic                  o_tx_start
);

  localparam int NB = BITS_SIZE / BITS_DATA;
  localparam int CW = $clog2(NB + 1);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_byte_cnt;
  logic [BITS_SIZE-1:0]  r_data_a;
  logic [BITS_SIZE-1:0]  r_data_b;
  logic [BITS_OP-1:0]    r_op;
  logic [BITS_SHAMT-1:0] r_shamt;
  logic                  r_flag;
  logic [BITS_SIZE-1:0]  r_result;
  logic                  r_zero;
  logic                  w_last_rx;
  logic                  w_last_tx;
  logic [NB:0][BITS_DATA-1:0] w_tx_bytes;

  assign w_last_rx = (r_byte_cnt == CW'(NB - 1));
  assign w_last_tx = (r_byte_cnt == CW'(NB));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= RX_A;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_A:     if (i_rx_done && w_last_rx) w_next = RX_B;
      RX_B:     if (i_rx_done && w_last_rx) w_next = RX_OP;
      RX_OP:    if (i_rx_done) w_next = RX_SHIFT;
      RX_SHIFT: if (i_rx_done) w_next = EXEC;
      EXEC:     w_next = TX_LOAD;
      TX_LOAD:  w_next = TX_WAIT;
      TX_WAIT:
        if (i_tx_done) w_next = w_last_tx ? RX_A : TX_LOAD;
      default:  w_next = RX_A;
    endcase
  end

  // byte_cnt indexes operand bytes on RX and the outgoing byte on TX
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_byte_cnt <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_op       <= '0;
      r_shamt    <= '0;
      r_flag     <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        RX_A: if (i_rx_done) begin
          r_data_a[r_byte_cnt*BITS_DATA +: BITS_DATA] <= i_rx_data;
          r_byte_cnt <= w_last_rx ? '0 : r_byte_cnt + 1'b1;
        end
        RX_B: if (i_rx_done) begin
          r_data_b[r_byte_cnt*BITS_DATA +: BITS_DATA] <= i_rx_data;
          r_byte_cnt <= w_last_rx ? '0 : r_byte_cnt + 1'b1;
        end
        RX_OP: if (i_rx_done) r_op <= i_rx_data[BITS_OP-1:0];
        RX_SHIFT: if (i_rx_done) begin
          r_flag  <= i_rx_data[7];
          r_shamt <= i_rx_data[BITS_SHAMT-1:0];
        end
        EXEC: begin
          r_result   <= i_alu_result;
          r_zero     <= i_alu_zero;
          r_byte_cnt <= '0;
        end
        TX_WAIT: if (i_tx_done)
          r_byte_cnt <= w_last_tx ? '0 : r_byte_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign w_tx_bytes   = {{(BITS_DATA-1){1'b0}}, r_zero, r_result};
  assign o_tx_data    = w_tx_bytes[r_byte_cnt];
  assign o_tx_start   = (r_state == TX_LOAD);
  assign o_data_a     = r_data_a;
  assign o_data_b     = r_data_b;
  assign o_op         = r_op;
  assign o_alu_shamt  = r_shamt;
  assign o_flag_shamt = r_flag;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench: frames are pushed with their expected TX bytes,
// a monitor pops and checks each byte the bridge starts sending.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_uart_interface_if u_if ();

  logic       tx_done_r = 1'b0;
  logic       tx_done_f = 1'b0;
  int         tx_delay  = 3;
  logic [7:0] exp_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         n_starts  = 0;
  bit         waiting   = 0;
  logic [7:0] hold_b    = '0;

  assign u_if.tx_done = tx_done_r | tx_done_f;

  alu_uart_interface dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (u_if.rx_data),
    .i_rx_done    (u_if.rx_done),
    .i_tx_done    (u_if.tx_done),
    .i_alu_result (u_if.alu_result),
    .i_alu_zero   (u_if.alu_zero),
    .o_data_a     (u_if.data_a),
    .o_data_b     (u_if.data_b),
    .o_op         (u_if.op),
    .o_alu_shamt  (u_if.shamt),
    .o_flag_shamt (u_if.flag_shamt),
    .o_tx_data    (u_if.tx_data),
    .o_tx_start   (u_if.tx_start)
  );

  always_comb begin
    case (u_if.op)
      OP_ADD:  u_if.alu_result = u_if.data_a + u_if.data_b;
      OP_SUB:  u_if.alu_result = u_if.data_a - u_if.data_b;
      OP_SLL:  u_if.alu_result = u_if.data_b << u_if.shamt;
      default: u_if.alu_result = '0;
    endcase
    u_if.alu_zero = (u_if.alu_result == '0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (u_if.tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_extra: got byte %h expected none",
                 u_if.tx_data);
      end else begin
        chk("tx_byte", {24'h0, u_if.tx_data}, {24'h0, exp_q.pop_front()});
      end
      hold_b  = u_if.tx_data;
      waiting = 1;
    end else if (waiting) begin
      chk("tx_hold", {24'h0, u_if.tx_data}, {24'h0, hold_b});
      if (u_if.tx_done) waiting = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (u_if.tx_start) begin
        repeat (tx_delay) @(posedge clk);
        #1 tx_done_r = 1'b1;
        @(posedge clk);
        #1 tx_done_r = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit last);
    @(posedge clk);
    #1;
    u_if.rx_data = d;
    u_if.rx_done = 1'b1;
    @(posedge clk);
    #1;
    u_if.rx_done = 1'b0;
    if (last) begin
      chk("lat_c1", {31'h0, u_if.tx_start}, 32'h0);
      @(posedge clk);
      #1;
      chk("lat_c2", {31'h0, u_if.tx_start}, 32'h1);
    end
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] op, input logic [7:0] sh,
                            input logic [39:0] exp);
    logic [39:0] e;
    e = exp;
    for (int i = 0; i < TX_FRAME_BYTES; i++) exp_q.push_back(e[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b0);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], 1'b0);
    send_byte(op, 1'b0);
    send_byte(sh, 1'b1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || waiting) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    u_if.rx_data = '0;
    u_if.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_a", u_if.data_a, 32'h0);
    chk("rst_b", u_if.data_b, 32'h0);
    chk("rst_op", {26'h0, u_if.op}, 32'h0);
    chk("rst_start", {31'h0, u_if.tx_start}, 32'h0);
    chk("rst_txd", {24'h0, u_if.tx_data}, 32'h0);

    // 5 + 3 = 8, zero flag clear
    send_frame(32'h5, 32'h3, 8'h20, 8'h00, 40'h00_00_00_00_08);
    wait_drain();
    chk("hold_a", u_if.data_a, 32'h5);
    chk("hold_b", u_if.data_b, 32'h3);
    chk("hold_op", {26'h0, u_if.op}, 32'h20);

    // equal operands subtract to zero, status byte = 1
    send_frame(32'h12345678, 32'h12345678, 8'h22, 8'h00,
               40'h01_00_00_00_00);
    wait_drain();

    // shift byte 0x84: flag set, shamt 4, 1 << 4 = 0x10
    send_frame(32'h0, 32'h1, 8'h00, 8'h84, 40'h00_00_00_00_10);
    chk("flag_shamt", {31'h0, u_if.flag_shamt}, 32'h1);
    chk("alu_shamt", {27'h0, u_if.shamt}, 32'h4);
    wait_drain();

    // slow transmitter plus stray rx pulses that must be dropped
    tx_delay = 20;
    send_frame(32'hFF, 32'h1, 8'hE0, 8'h00, 40'h00_00_00_01_00);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hAA, 1'b0);
      @(posedge clk);
    end
    wait_drain();
    tx_delay = 3;
    chk("starts_4", n_starts, 32'd20);

    // abort after 6 bytes with reset colliding with rx/tx done
    for (int i = 0; i < 6; i++) send_byte(8'h5A, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    u_if.rx_done = 1'b1;
    tx_done_f = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    u_if.rx_done = 1'b0;
    tx_done_f = 1'b0;
    chk("abort_a", u_if.data_a, 32'h0);
    chk("abort_b", u_if.data_b, 32'h0);
    chk("abort_op", {26'h0, u_if.op}, 32'h0);
    chk("abort_sh", {26'h0, u_if.flag_shamt, u_if.shamt}, 32'h0);
    chk("abort_start", {31'h0, u_if.tx_start}, 32'h0);

    send_frame(32'hFFFFFFFF, 32'h1, 8'h20, 8'h00, 40'h01_00_00_00_00);
    wait_drain();
    chk("total_starts", n_starts, 32'd25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
